// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures WB register writes and MEM stores with a cycle stamp
// and drains them in program order over a first-word-fall-through valid/ready port.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wb_we_i,
  input  logic [4:0]              wb_addr_i,
  input  logic [31:0]             wb_data_i,
  input  logic                    st_we_i,
  input  logic [31:0]             st_addr_i,
  input  logic [31:0]             st_data_i,
  output logic                    trc_valid_o,
  input  logic                    trc_ready_i,
  output logic                    trc_type_o,
  output logic [31:0]             trc_addr_o,
  output logic [31:0]             trc_data_o,
  output logic [CYC_W-1:0]        trc_cyc_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef struct packed {
    logic             typ;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [CYC_W-1:0] cyc;
  } entry_t;

  entry_t           mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic [PW-1:0]    count;
  logic [PW-1:0]    free;
  logic             wb_ev, st_ev, pop;
  entry_t           wb_ent, st_ent, wr0_ent, wr1_ent, head;
  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_idx, wr1_idx;
  logic [1:0]       n_push, n_drop;
  logic [16:0]      drop_sum;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    free    = DEPTH_P - count;
    wb_ev   = wb_we_i && (wb_addr_i != 5'd0);
    st_ev   = st_we_i;
    pop     = (count != '0) && trc_ready_i;

    wb_ent  = '{typ: 1'b0, addr: {27'd0, wb_addr_i}, data: wb_data_i, cyc: cyc_q};
    st_ent  = '{typ: 1'b1, addr: st_addr_i, data: st_data_i, cyc: cyc_q};

    wr0_en  = 1'b0;
    wr1_en  = 1'b0;
    wr0_ent = wb_ent;
    wr1_ent = st_ent;
    n_push  = 2'd0;
    n_drop  = 2'd0;

    // Room is judged on the start-of-cycle count; the older WB event claims a lone free slot.
    if (wb_ev && st_ev) begin
      if (free >= PW'(2)) begin
        wr0_en = 1'b1;
        wr1_en = 1'b1;
        n_push = 2'd2;
      end else if (free == PW'(1)) begin
        wr0_en = 1'b1;
        n_push = 2'd1;
        n_drop = 2'd1;
      end else begin
        n_drop = 2'd2;
      end
    end else if (wb_ev || st_ev) begin
      wr0_ent = wb_ev ? wb_ent : st_ent;
      if (free != '0) begin
        wr0_en = 1'b1;
        n_push = 2'd1;
      end else begin
        n_drop = 2'd1;
      end
    end

    wr0_idx    = wr_ptr_q[AW-1:0];
    wr1_idx    = wr0_idx + AW'(1);

    wr_ptr_d   = wr_ptr_q + PW'(n_push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    cyc_d      = cyc_q + CYC_W'(1);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | (n_drop != 2'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cyc_q      <= cyc_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (wr0_en) mem[wr0_idx] <= wr0_ent;
    if (wr1_en) mem[wr1_idx] <= wr1_ent;
  end

  // Outputs depend only on registered state; fields are forced to zero while empty.
  always_comb begin
    head        = mem[rd_ptr_q[AW-1:0]];
    trc_valid_o = (count != '0);
    trc_type_o  = trc_valid_o & head.typ;
    trc_addr_o  = trc_valid_o ? head.addr : '0;
    trc_data_o  = trc_valid_o ? head.data : '0;
    trc_cyc_o   = trc_valid_o ? head.cyc  : '0;
    count_o     = count;
    overflow_o  = overflow_q;
    drop_cnt_o  = drop_cnt_q;
  end

endmodule
